// File: rtl/mux_stage_pkg.sv
// Shared types and helpers for the operand-select skid stage and its N:1 mux.
package mux_stage_pkg;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} skid_state_t;

  // Select width for an n-way mux; a degenerate 1-way mux still gets one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_n_1.sv
// Combinational N:1 word select; a select at or beyond N_IN yields all-zero.
// Zero latency, no flow control.
module mux_n_1
  import mux_stage_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int N_IN  = 4,
  localparam int SEL_W = sel_width(N_IN)
) (
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      out_data
);

  always_comb begin
    out_data = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (int'(sel) == k) out_data = in_data[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/mux_skid_stage.sv
// N-way operand select into a 2-entry skid pipeline register; 1-cycle latency.
// in_ready depends only on the state register, so out_ready never reaches upstream combinationally.
module mux_skid_stage
  import mux_stage_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int N_IN  = 4,
  localparam int SEL_W = sel_width(N_IN)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sel_err
);

  skid_state_t      state, state_nxt;
  logic [WIDTH-1:0] sel_word;
  logic [WIDTH-1:0] skid;
  logic             acc, drn, sel_bad;
  logic             load_out, load_skid, pop_skid;

  mux_n_1 #(.WIDTH(WIDTH), .N_IN(N_IN)) u_mux (
    .in_data  (in_data),
    .sel      (in_sel),
    .out_data (sel_word)
  );

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign acc       = in_valid & in_ready;
  assign drn       = out_valid & out_ready;
  assign sel_bad   = (int'(in_sel) >= N_IN);

  always_comb begin
    state_nxt = state;
    load_out  = 1'b0;
    load_skid = 1'b0;
    pop_skid  = 1'b0;
    case (state)
      EMPTY: begin
        if (acc) begin
          state_nxt = ONE;
          load_out  = 1'b1;
        end
      end
      ONE: begin
        if (acc && drn) begin
          load_out = 1'b1;
        end else if (acc) begin
          state_nxt = FULL;
          load_skid = 1'b1;
        end else if (drn) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (drn) begin
          state_nxt = ONE;
          pop_skid  = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // Flush squashes everything, including a word accepted this same cycle.
    if (flush) begin
      state_nxt = EMPTY;
      load_out  = 1'b0;
      load_skid = 1'b0;
      pop_skid  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data <= '0;
      skid     <= '0;
      sel_err  <= 1'b0;
    end else begin
      if (load_out)      out_data <= sel_word;
      else if (pop_skid) out_data <= skid;
      if (load_skid)     skid     <= sel_word;
      if (acc && !flush && sel_bad) sel_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mux_skid_stage.sv
// Directed and streamed checks of mux_skid_stage against an occupancy/scoreboard model.
module tb_mux_skid_stage;

  localparam logic [63:0] C = 64'h0100_0000_0000_0000;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] in_data;
  logic [1:0]   in_sel;
  logic         in_valid, in_ready, flush, out_valid, out_ready, sel_err;
  logic [63:0]  out_data;

  logic [191:0] in_data3;
  logic [1:0]   in_sel3;
  logic         in_valid3, in_ready3, flush3, out_valid3, out_ready3, sel_err3;
  logic [63:0]  out_data3;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] sbq[$];
  logic        hold_chk = 1'b0;
  logic [63:0] held = '0;

  always #5 clk = ~clk;

  mux_skid_stage #(.WIDTH(64), .N_IN(4)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sel_err(sel_err)
  );

  mux_skid_stage #(.WIDTH(64), .N_IN(3)) dut3 (
    .clk(clk), .reset(reset), .in_data(in_data3), .in_sel(in_sel3),
    .in_valid(in_valid3), .in_ready(in_ready3), .flush(flush3),
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
    .sel_err(sel_err3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One cycle on the 4-way instance: source k carries base + k*C.
  task automatic cyc(input logic v, input logic [1:0] s, input logic [63:0] base,
                     input logic ordy, input logic fl, output logic acc_o);
    logic        drn;
    logic [63:0] expv;
    @(negedge clk);
    in_valid  = v;
    in_sel    = s;
    out_ready = ordy;
    flush     = fl;
    for (int k = 0; k < 4; k++) in_data[k*64 +: 64] = base + 64'(k) * C;
    #1;
    chk("out_valid", 64'(out_valid), 64'(sbq.size() != 0));
    chk("in_ready", 64'(in_ready), 64'(sbq.size() < 2));
    if (hold_chk) chk("stall_hold", out_data, held);
    acc_o = v & in_ready;
    drn   = out_valid & ordy;
    if (drn) begin
      if (sbq.size() == 0) chk("spurious_out", 64'(out_valid), 64'd0);
      else begin
        expv = sbq.pop_front();
        chk("out_data", out_data, expv);
      end
    end
    if (fl) sbq.delete();
    else if (acc_o) sbq.push_back(base + 64'(s) * C);
    hold_chk = out_valid & ~ordy & ~fl;
    held     = out_data;
  endtask

  task automatic drain();
    logic a;
    int   budget = 50;
    while (sbq.size() != 0 && budget > 0) begin
      cyc(1'b0, 2'd0, 64'd0, 1'b1, 1'b0, a);
      budget--;
    end
    chk("drain_empty", 64'(sbq.size()), 64'd0);
  endtask

  task automatic cyc3(input logic v, input logic [1:0] s, input logic ordy, input logic fl);
    @(negedge clk);
    in_valid3  = v;
    in_sel3    = s;
    out_ready3 = ordy;
    flush3     = fl;
    #1;
  endtask

  initial begin
    logic a;
    int   i, budget;
    logic [1:0] s;
    reset = 1'b1;
    in_data = '0; in_sel = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_data3 = {64'h33, 64'h22, 64'h11};
    in_sel3 = '0; in_valid3 = 1'b0; flush3 = 1'b0; out_ready3 = 1'b0;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_sel_err", 64'(sel_err), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Single word, 1-cycle latency, then back to empty.
    cyc(1'b1, 2'd2, 64'hDEAD_BEEF_0000_0001 - 2 * C, 1'b1, 1'b0, a);
    chk("t1_acc", 64'(a), 64'd1);
    cyc(1'b0, 2'd0, 64'd0, 1'b1, 1'b0, a);
    chk("t1_word", out_data, 64'hDEAD_BEEF_0000_0001);
    cyc(1'b0, 2'd0, 64'd0, 1'b1, 1'b0, a);

    // Fill to FULL under stall, then release.
    cyc(1'b1, 2'd0, 64'd1, 1'b0, 1'b0, a);
    cyc(1'b1, 2'd0, 64'd2, 1'b0, 1'b0, a);
    cyc(1'b0, 2'd0, 64'd0, 1'b0, 1'b0, a);
    chk("t2_full_in_ready", 64'(in_ready), 64'd0);
    cyc(1'b0, 2'd0, 64'd0, 1'b1, 1'b0, a);
    chk("t2_first_A", out_data, 64'd1);
    cyc(1'b0, 2'd0, 64'd0, 1'b1, 1'b0, a);
    chk("t2_then_B", out_data, 64'd2);
    drain();

    // Full throughput with out_ready held high.
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, 2'(k), 64'h500 + 64'(k), 1'b1, 1'b0, a);
      chk("thru_acc", 64'(a), 64'd1);
    end
    drain();

    // Stream 0..99 with random select and random backpressure.
    i = 0;
    budget = 2000;
    while (i < 100 && budget > 0) begin
      s = 2'($urandom_range(0, 3));
      cyc(1'b1, s, 64'(i), ($urandom_range(0, 2) != 0), 1'b0, a);
      if (a) i++;
      budget--;
    end
    chk("stream_count", 64'(i), 64'd100);
    drain();

    // Flush while FULL with a word offered; flush while ONE with a word accepted.
    cyc(1'b1, 2'd1, 64'h700, 1'b0, 1'b0, a);
    cyc(1'b1, 2'd1, 64'h701, 1'b0, 1'b0, a);
    cyc(1'b1, 2'd1, 64'h702, 1'b0, 1'b1, a);
    cyc(1'b0, 2'd0, 64'd0, 1'b1, 1'b0, a);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    cyc(1'b1, 2'd3, 64'h710, 1'b0, 1'b0, a);
    cyc(1'b1, 2'd3, 64'h711, 1'b0, 1'b1, a);
    cyc(1'b1, 2'd0, 64'h720, 1'b1, 1'b0, a);
    cyc(1'b0, 2'd0, 64'd0, 1'b1, 1'b0, a);
    chk("post_flush_word", out_data, 64'h720);
    drain();

    // 3-way instance: flushed illegal select leaves sel_err clear.
    cyc3(1'b1, 2'd3, 1'b1, 1'b1);
    cyc3(1'b0, 2'd0, 1'b1, 1'b0);
    chk("n3_flush_sel_err", 64'(sel_err3), 64'd0);
    chk("n3_flush_valid", 64'(out_valid3), 64'd0);
    cyc3(1'b1, 2'd3, 1'b1, 1'b0);
    cyc3(1'b0, 2'd0, 1'b1, 1'b0);
    chk("n3_bad_valid", 64'(out_valid3), 64'd1);
    chk("n3_bad_data", out_data3, 64'd0);
    chk("n3_sel_err_set", 64'(sel_err3), 64'd1);
    cyc3(1'b1, 2'd1, 1'b1, 1'b0);
    cyc3(1'b0, 2'd0, 1'b0, 1'b0);
    chk("n3_legal_data", out_data3, 64'h22);
    chk("n3_sel_err_sticky", 64'(sel_err3), 64'd1);
    cyc3(1'b1, 2'd0, 1'b0, 1'b0);
    cyc3(1'b0, 2'd0, 1'b0, 1'b0);
    chk("n3_full_in_ready", 64'(in_ready3), 64'd0);
    chk("n3_full_hold", out_data3, 64'h22);

    // Asynchronous reset mid-cycle while FULL.
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid3), 64'd0);
    chk("arst_out_data", out_data3, 64'd0);
    chk("arst_sel_err", 64'(sel_err3), 64'd0);
    chk("arst_in_ready", 64'(in_ready3), 64'd1);
    chk("arst_dut4_valid", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
